rom_byte_reader: RTL and testbench
==================================

ROM_BYTE_READER -- requirements
Module: rom_byte_reader

Interface
REQ-001 The block SHALL have parameter ROM_ADDR_W, default 9, ROM word-address width.
REQ-002 The block SHALL have parameter BYTE_ADDR_W, default ROM_ADDR_W+1, byte-address width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req  input  1  byte-read request, sampled only in IDLE.
REQ-006 The block SHALL have port byte_addr  input  BYTE_ADDR_W  byte address of the request.
REQ-007 The block SHALL have port flush  input  1  invalidates the word buffer.
REQ-008 The block SHALL have port busy  output  1  high while a ROM fetch is in flight.
REQ-009 The block SHALL have port ready  output  1  one-cycle pulse, rdata valid.
REQ-010 The block SHALL have port rdata  output  8  requested byte, held until the next ready.
REQ-011 The block SHALL have port rom_enable  output  1  drives the ROM enable.
REQ-012 The block SHALL have port rom_addr  output  ROM_ADDR_W  drives the ROM word address.
REQ-013 The block SHALL have port rom_data  input  16  ROM read data, valid one cycle after the address edge.

Function
REQ-014 Byte select SHALL be little-endian: byte_addr[0]=0 selects rom_data[7:0], =1 selects rom_data[15:8]; word index = byte_addr[BYTE_ADDR_W-1:1].
REQ-015 The block SHALL keep a one-word buffer: buf_word[15:0], buf_addr[ROM_ADDR_W-1:0], buf_valid.
REQ-016 FSM states SHALL be IDLE, FETCH, CAPTURE.
REQ-017 IDLE, req=1, buf_valid=1, word index==buf_addr, flush=0 (hit): next edge sets rdata from buf_word, ready=1, state stays IDLE; latency 1 cycle.
REQ-018 IDLE, req=1, miss: next edge registers rom_addr=word index, rom_enable=1, busy=1, latches byte select, state->FETCH.
REQ-019 FETCH: next edge unconditionally ->CAPTURE; rom_enable and rom_addr held.
REQ-020 CAPTURE: next edge latches rom_data into buf_word, sets buf_addr, buf_valid=1, rdata=selected byte, ready=1, rom_enable=0, busy=0, ->IDLE; miss latency 3 cycles.
REQ-021 req in FETCH/CAPTURE SHALL be ignored; requester must hold off while busy=1.
REQ-022 flush in any state SHALL clear buf_valid at the next edge; flush with req in IDLE SHALL be treated as a miss.
REQ-023 flush during FETCH/CAPTURE SHALL not abort the fetch; the captured word SHALL be marked valid.
REQ-024 ready SHALL be high for exactly one cycle per accepted request, otherwise 0.
REQ-025 rom_enable SHALL be 0 in IDLE, so an ungated ROM output of 0 never corrupts rdata.
REQ-026 Byte addresses SHALL wrap by truncation to BYTE_ADDR_W; no out-of-range error.

Reset
REQ-027 reset SHALL asynchronously force state=IDLE, ready=0, busy=0, rom_enable=0, rom_addr=0, rdata=0, buf_valid=0, buf_word=0, buf_addr=0.
REQ-028 reset mid-fetch SHALL abort without a ready pulse; the first request after reset release SHALL be a miss.

Structure
REQ-029 The FSM state enum and the byte-lane constants SHALL live in a shared package, reflet_rom_pkg.
REQ-030 No sub-module is required; the ROM (rom5 or equivalent) SHALL be instantiated only by the integrating level or testbench.

Verification (bench pairs the block with the ASRM-header ROM image: word0=0x5341, word1=0x4D52)
REQ-031 Reset, req byte_addr=0 -> ready 3 cycles later, rdata=0x41, one rom_enable window of 2 cycles.
REQ-032 Then req byte_addr=1 -> ready after 1 cycle, rdata=0x53, rom_enable stays 0.
REQ-033 req byte_addr=2 then 3 -> 0x52 after 3 cycles (miss), 0x4D after 1 cycle (hit).
REQ-034 flush with req byte_addr=3 in the same cycle -> treated as miss, rdata=0x4D after 3 cycles.
REQ-035 Assert reset during FETCH of byte_addr=0x20 -> no ready, all outputs 0; subsequent req byte_addr=0x20 -> miss, rdata=0x00 (low byte of word 0x10=0x8000) after 3 cycles.
REQ-036 req toggled while busy=1 -> ignored; exactly one ready per accepted request.

Source files
------------

// File: rtl/reflet_rom_pkg.sv
// Shared definitions for the ROM byte reader: FSM state encoding and byte-lane helpers.
package reflet_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic lane);
    return (lane == LANE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/rom_byte_reader.sv
// Byte-wide reader in front of a 16-bit synchronous ROM, with a one-word buffer
// so consecutive bytes of the same word are served without a ROM fetch.
module rom_byte_reader
  import reflet_rom_pkg::*;
#(
  parameter int ROM_ADDR_W  = 9,
  parameter int BYTE_ADDR_W = ROM_ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic [BYTE_ADDR_W-1:0] byte_addr,
  input  logic                   flush,
  output logic                   busy,
  output logic                   ready,
  output logic [7:0]             rdata,
  output logic                   rom_enable,
  output logic [ROM_ADDR_W-1:0]  rom_addr,
  input  logic [15:0]            rom_data
);

  state_t                state_reg, state_next;
  logic                  ready_reg, ready_next;
  logic                  busy_reg, busy_next;
  logic                  rom_enable_reg, rom_enable_next;
  logic [ROM_ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic [7:0]            rdata_reg, rdata_next;
  logic [15:0]           buf_word_reg, buf_word_next;
  logic [ROM_ADDR_W-1:0] buf_addr_reg, buf_addr_next;
  logic                  buf_valid_reg, buf_valid_next;
  logic                  lane_reg, lane_next;

  logic [ROM_ADDR_W-1:0] word_idx;
  logic                  hit;

  assign word_idx = ROM_ADDR_W'(byte_addr[BYTE_ADDR_W-1:1]);
  // A flush in the same cycle as the request forces a refetch.
  assign hit      = buf_valid_reg && (word_idx == buf_addr_reg) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      ready_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      rom_enable_reg <= 1'b0;
      rom_addr_reg   <= '0;
      rdata_reg      <= '0;
      buf_word_reg   <= '0;
      buf_addr_reg   <= '0;
      buf_valid_reg  <= 1'b0;
      lane_reg       <= LANE_LO;
    end else begin
      state_reg      <= state_next;
      ready_reg      <= ready_next;
      busy_reg       <= busy_next;
      rom_enable_reg <= rom_enable_next;
      rom_addr_reg   <= rom_addr_next;
      rdata_reg      <= rdata_next;
      buf_word_reg   <= buf_word_next;
      buf_addr_reg   <= buf_addr_next;
      buf_valid_reg  <= buf_valid_next;
      lane_reg       <= lane_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ready_next      = 1'b0;
    busy_next       = busy_reg;
    rom_enable_next = rom_enable_reg;
    rom_addr_next   = rom_addr_reg;
    rdata_next      = rdata_reg;
    buf_word_next   = buf_word_reg;
    buf_addr_next   = buf_addr_reg;
    buf_valid_next  = flush ? 1'b0 : buf_valid_reg;
    lane_next       = lane_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            rdata_next = select_byte(buf_word_reg, byte_addr[0]);
            ready_next = 1'b1;
          end else begin
            rom_addr_next   = word_idx;
            rom_enable_next = 1'b1;
            busy_next       = 1'b1;
            lane_next       = byte_addr[0];
            state_next      = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // The freshly captured word is valid even if a flush arrived mid-fetch.
        buf_word_next   = rom_data;
        buf_addr_next   = rom_addr_reg;
        buf_valid_next  = 1'b1;
        rdata_next      = select_byte(rom_data, lane_reg);
        ready_next      = 1'b1;
        rom_enable_next = 1'b0;
        busy_next       = 1'b0;
        state_next      = ST_IDLE;
      end
      default: begin
        state_next      = ST_IDLE;
        rom_enable_next = 1'b0;
        busy_next       = 1'b0;
      end
    endcase
  end

  assign busy       = busy_reg;
  assign ready      = ready_reg;
  assign rdata      = rdata_reg;
  assign rom_enable = rom_enable_reg;
  assign rom_addr   = rom_addr_reg;

endmodule

// File: tb/tb_rom_byte_reader.sv
// Randomized self-checking bench for rom_byte_reader against a word-buffer
// reference model and a synchronous ROM holding the ASRM header image.
module tb_rom_byte_reader;

  localparam int ROM_ADDR_W  = 9;
  localparam int BYTE_ADDR_W = 10;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req;
  logic [BYTE_ADDR_W-1:0] byte_addr;
  logic                   flush;
  logic                   busy;
  logic                   ready;
  logic [7:0]             rdata;
  logic                   rom_enable;
  logic [ROM_ADDR_W-1:0]  rom_addr;
  logic [15:0]            rom_data;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:(1<<ROM_ADDR_W)-1];

  // Reference model of the buffer: which word (if any) the reader should hold.
  bit m_valid;
  int m_word;

  rom_byte_reader #(.ROM_ADDR_W(ROM_ADDR_W), .BYTE_ADDR_W(BYTE_ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .byte_addr(byte_addr), .flush(flush),
    .busy(busy), .ready(ready), .rdata(rdata), .rom_enable(rom_enable),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the address edge, 0 when disabled.
  always @(posedge clk) rom_data <= rom_enable ? mem[rom_addr] : 16'h0000;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One request; expected values come from the model and the ROM image.
  task automatic do_req(input int addr, input bit fl, input bit junk);
    int  a, widx, exp_byte, exp_lat, lat, en_cnt, busy_cnt, rdy_cnt;
    bit  hit;
    a        = addr & ((1 << BYTE_ADDR_W) - 1);
    widx     = a >> 1;
    hit      = m_valid && !fl && (m_word == widx);
    exp_byte = (a & 1) ? int'(mem[widx][15:8]) : int'(mem[widx][7:0]);
    exp_lat  = hit ? 1 : 3;
    lat = 0; en_cnt = 0; busy_cnt = 0; rdy_cnt = 0;
    @(negedge clk);
    req = 1'b1; byte_addr = a[BYTE_ADDR_W-1:0]; flush = fl;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      en_cnt   += int'(rom_enable);
      busy_cnt += int'(busy);
      if (ready) begin
        lat = c; rdy_cnt++;
        break;
      end
      @(negedge clk);
      if (busy && junk) begin
        req = 1'($urandom_range(0, 1));
        byte_addr = BYTE_ADDR_W'($urandom);
        flush = 1'($urandom_range(0, 1));
      end else begin
        req = 1'b0; flush = 1'b0;
      end
    end
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      rdy_cnt += int'(ready);
    end
    m_valid = 1'b1;
    m_word  = widx;
    $display("req addr=0x%03h flush=%0d hit=%0d lat=%0d rdata=0x%02h exp=0x%02h",
             a, fl, hit, lat, rdata, exp_byte);
    check_val("latency", lat, exp_lat);
    check_val("rdata", int'(rdata), exp_byte);
    check_val("ready_count", rdy_cnt, 1);
    check_val("rom_en_cycles", en_cnt, hit ? 0 : 2);
    check_val("busy_cycles", busy_cnt, hit ? 0 : 2);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, int'(ready), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_rom_en"}, int'(rom_enable), 0);
    check_val({tag, "_rom_addr"}, int'(rom_addr), 0);
    check_val({tag, "_rdata"}, int'(rdata), 0);
  endtask

  initial begin
    int rdy_cnt;
    for (int i = 0; i < (1 << ROM_ADDR_W); i++) mem[i] = 16'($urandom);
    mem[0]     = 16'h5341;
    mem[1]     = 16'h4D52;
    mem[16'h10] = 16'h8000;
    m_valid = 1'b0; m_word = 0;
    reset = 1'b1; req = 1'b0; flush = 1'b0; byte_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    $display("reset state checked");
    @(negedge clk); reset = 1'b0;

    // Directed sequence over the ASRM header.
    do_req(0, 1'b0, 1'b0);
    do_req(1, 1'b0, 1'b0);
    do_req(2, 1'b0, 1'b0);
    do_req(3, 1'b0, 1'b0);
    do_req(3, 1'b1, 1'b0);

    // Reset during the fetch of byte 0x20: no ready, everything cleared.
    @(negedge clk);
    req = 1'b1; byte_addr = 10'h020; flush = 1'b0;
    @(posedge clk); #1;
    check_val("midfetch_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1 check_all_zero("midfetch_reset");
    rdy_cnt = 0;
    @(negedge clk); req = 1'b0;
    repeat (2) begin @(posedge clk); #1; rdy_cnt += int'(ready); end
    @(negedge clk); reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; rdy_cnt += int'(ready); end
    check_val("midfetch_no_ready", rdy_cnt, 0);
    $display("reset during fetch checked ready_pulses=%0d", rdy_cnt);
    m_valid = 1'b0;
    do_req(10'h020, 1'b0, 1'b0);

    // Wraparound at the top of the byte space, then a toggling requester.
    do_req(10'h3FF, 1'b0, 1'b1);
    do_req(10'h3FE, 1'b0, 1'b1);

    // Randomized traffic, biased towards reuse of the buffered word.
    for (int t = 0; t < 80; t++) begin
      int a;
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk); flush = 1'b1; req = 1'b0;
        @(negedge clk); flush = 1'b0;
        m_valid = 1'b0;
        $display("idle flush");
      end
      if ($urandom_range(0, 1) == 1) a = (m_word << 1) | int'($urandom_range(0, 1));
      else a = int'($urandom_range(0, (1 << BYTE_ADDR_W) - 1));
      do_req(a, ($urandom_range(0, 4) == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
